// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
//   N_REQ   : number of requesters sharing the mux lane
//   idx_t   : requester index / mux select encoding
//   state_t : arbiter FSM states
package mux4_arb_pkg;

  localparam int unsigned N_REQ = 4;

  typedef logic [1:0] idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set bit of req searching from ptr upward, mod 4.
//   req   in  [3:0] : request vector
//   ptr   in  [1:0] : first index checked
//   found out       : at least one request set
//   idx   out [1:0] : winning index (ptr when nothing found)
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  idx_t             ptr,
  output logic             found,
  output idx_t             idx
);

  // Walk the four positions in priority order; the first hit locks the result.
  always_comb begin
    idx_t cand;
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = idx_t'(ptr + idx_t'(k));
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin, burst-limited owner arbitration for the shared 4:1 single-bit mux lane.
//   clk  in        : rising-edge clock
//   rst  in        : synchronous active-high reset
//   req  in  [3:0] : per-requester level request
//   in   in  [3:0] : per-requester data bit
//   gnt  out [3:0] : one-hot grant (registered), zero when idle
//   sel  out [1:0] : owner index (registered), drives the mux select
//   busy out       : grant active (registered)
//   out  out       : in[sel] while busy, else 0 (combinational)
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] in,
  output logic [N_REQ-1:0] gnt,
  output idx_t             sel,
  output logic             busy,
  output logic             out
);

  localparam int unsigned     CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  state_t           state, state_nxt;
  idx_t             ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  idx_t             sel_nxt;
  logic             busy_nxt;

  logic             pick_found;
  idx_t             pick_idx;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // State, pointer, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      gnt   <= '0;
      sel   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      gnt   <= gnt_nxt;
      sel   <= sel_nxt;
      busy  <= busy_nxt;
    end
  end

  // Next-state: hold by default; load a new owner on pick, or fall idle with sel frozen.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    busy_nxt  = busy;

    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = GRANT;
          sel_nxt   = pick_idx;
          gnt_nxt   = N_REQ'(1) << pick_idx;
          busy_nxt  = 1'b1;
          cnt_nxt   = CNT_W'(1);
          ptr_nxt   = idx_t'(pick_idx + idx_t'(1));
        end
      end
      GRANT: begin
        if (req[sel] && (cnt != CNT_MAX)) begin
          cnt_nxt = cnt + CNT_W'(1);
        end else if (pick_found) begin
          // ptr already points past the owner, so the owner is searched last.
          sel_nxt   = pick_idx;
          gnt_nxt   = N_REQ'(1) << pick_idx;
          cnt_nxt   = CNT_W'(1);
          ptr_nxt   = idx_t'(pick_idx + idx_t'(1));
        end else begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
        end
      end
    endcase
  end

  assign out = busy & in[sel];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] in  = 4'b0000;

  logic [3:0] gnt_a  [3];
  logic [1:0] sel_a  [3];
  logic       busy_a [3];
  logic       out_a  [3];

  int n_cmp = 0;
  int n_err = 0;

  // Model state per instance (burst 2, 3, 8).
  int bursts [3] = '{2, 3, 8};
  int m_sel  [3] = '{0, 0, 0};
  int m_cnt  [3] = '{0, 0, 0};
  int m_ptr  [3] = '{0, 0, 0};
  bit m_busy [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.MAX_BURST(2)) d2 (
    .clk(clk), .rst(rst), .req(req), .in(in),
    .gnt(gnt_a[0]), .sel(sel_a[0]), .busy(busy_a[0]), .out(out_a[0]));
  mux4_rr_arbiter #(.MAX_BURST(3)) d3 (
    .clk(clk), .rst(rst), .req(req), .in(in),
    .gnt(gnt_a[1]), .sel(sel_a[1]), .busy(busy_a[1]), .out(out_a[1]));
  mux4_rr_arbiter #(.MAX_BURST(8)) d8 (
    .clk(clk), .rst(rst), .req(req), .in(in),
    .gnt(gnt_a[2]), .sel(sel_a[2]), .busy(busy_a[2]), .out(out_a[2]));

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Reference model: owner/count/pointer advanced by the arbitration rules.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      int w;
      if (rst) begin
        m_busy[d] = 0; m_sel[d] = 0; m_cnt[d] = 0; m_ptr[d] = 0;
      end else if (!m_busy[d] || !req[m_sel[d]] || m_cnt[d] == bursts[d]) begin
        w = pick(req, m_ptr[d]);
        if (w >= 0) begin
          m_busy[d] = 1; m_sel[d] = w; m_cnt[d] = 1; m_ptr[d] = (w + 1) % 4;
        end else begin
          m_busy[d] = 0;
        end
      end else begin
        m_cnt[d] = m_cnt[d] + 1;
      end
    end
  end

  function automatic logic [3:0] exp_gnt(input int d);
    return m_busy[d] ? (4'b0001 << m_sel[d]) : 4'b0000;
  endfunction

  function automatic logic exp_out(input int d);
    return m_busy[d] ? in[m_sel[d]] : 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    in  = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (gnt_a[d] !== 4'b0000 || sel_a[d] !== 2'd0 || busy_a[d] !== 1'b0 || out_a[d] !== 1'b0) begin
          n_err++;
          $display("FAIL reset d%0d: gnt=%b sel=%0d busy=%b out=%b, required all zero",
                   d, gnt_a[d], sel_a[d], busy_a[d], out_a[d]);
        end
      end
    end
    rst = 1'b0;
    tick();
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (gnt_a[d] !== 4'b0001 || busy_a[d] !== 1'b1) begin
        n_err++;
        $display("FAIL reset_release d%0d: gnt=%b busy=%b, required 0001 1", d, gnt_a[d], busy_a[d]);
      end
    end
  endtask

  task automatic test_rotation();
    int exp_rot [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    logic [3:0] e;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      tick();
      e = 4'b0001 << exp_rot[i];
      n_cmp++;
      if (gnt_a[0] !== e || sel_a[0] !== 2'(exp_rot[i]) || busy_a[0] !== 1'b1) begin
        n_err++;
        $display("FAIL rotation step %0d: gnt=%b sel=%0d busy=%b, required %b %0d 1",
                 i, gnt_a[0], sel_a[0], busy_a[0], e, exp_rot[i]);
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req = 4'b0100;
    tick();
    n_cmp++;
    if (gnt_a[2] !== 4'b0100) begin
      n_err++; $display("FAIL early_first: gnt=%b, required 0100", gnt_a[2]);
    end
    req = 4'b1001;
    tick();
    n_cmp++;
    if (gnt_a[2] !== 4'b1000 || sel_a[2] !== 2'd3) begin
      n_err++; $display("FAIL early_handover: gnt=%b sel=%0d, required 1000 3", gnt_a[2], sel_a[2]);
    end
    req = 4'b0001;
    tick();
    n_cmp++;
    if (gnt_a[2] !== 4'b0001 || sel_a[2] !== 2'd0) begin
      n_err++; $display("FAIL early_next: gnt=%b sel=%0d, required 0001 0", gnt_a[2], sel_a[2]);
    end
  endtask

  task automatic test_sole();
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++;
      if (gnt_a[1] !== 4'b0100 || busy_a[1] !== 1'b1 || sel_a[1] !== 2'd2) begin
        n_err++;
        $display("FAIL sole cycle %0d: gnt=%b busy=%b sel=%0d, required 0100 1 2",
                 i, gnt_a[1], busy_a[1], sel_a[1]);
      end
    end
  endtask

  task automatic test_datapath();
    do_reset();
    req = 4'b0010;
    in  = 4'b0010;
    tick();
    n_cmp++;
    if (out_a[2] !== 1'b1) begin
      n_err++; $display("FAIL data_one: out=%b, required 1", out_a[2]);
    end
    in = 4'b1101;
    #1;
    n_cmp++;
    if (out_a[2] !== 1'b0) begin
      n_err++; $display("FAIL data_zero: out=%b, required 0", out_a[2]);
    end
    req = 4'b0000;
    tick();
    in = 4'b1111;
    #1;
    n_cmp++;
    if (out_a[2] !== 1'b0 || busy_a[2] !== 1'b0 || gnt_a[2] !== 4'b0000 || sel_a[2] !== 2'd1) begin
      n_err++;
      $display("FAIL data_idle: out=%b busy=%b gnt=%b sel=%0d, required 0 0 0000 1",
               out_a[2], busy_a[2], gnt_a[2], sel_a[2]);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b1000;
    in  = 4'b1000;
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (gnt_a[2] !== 4'b0000 || sel_a[2] !== 2'd0 || busy_a[2] !== 1'b0 || out_a[2] !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: gnt=%b sel=%0d busy=%b out=%b, required all zero",
               gnt_a[2], sel_a[2], busy_a[2], out_a[2]);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (gnt_a[2] !== 4'b1000 || sel_a[2] !== 2'd3 || out_a[2] !== 1'b1) begin
      n_err++;
      $display("FAIL mid_regrant: gnt=%b sel=%0d out=%b, required 1000 3 1",
               gnt_a[2], sel_a[2], out_a[2]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      in = 4'($urandom_range(0, 15));
      tick();
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (gnt_a[d] !== exp_gnt(d) || busy_a[d] !== m_busy[d] ||
            sel_a[d] !== 2'(m_sel[d]) || out_a[d] !== exp_out(d)) begin
          n_err++;
          $display("FAIL random c%0d d%0d: gnt=%b sel=%0d busy=%b out=%b, required %b %0d %b %b",
                   c, d, gnt_a[d], sel_a[d], busy_a[d], out_a[d],
                   exp_gnt(d), m_sel[d], m_busy[d], exp_out(d));
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_early_release();
    test_sole();
    test_datapath();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
